// File: rtl/ptp_session_sequencer_if.sv
// Control/status and datapath handshake bundle for ptp_session_sequencer.
// The master side is the HPS register bank plus the ptp_sync datapath;
// the slave side is the sequencer itself.
interface ptp_session_sequencer_if #(
  parameter int unsigned ROUNDS_W = 4,
  parameter int unsigned TIME_W   = 32
);
  // Session commands and configuration
  logic                       cmd_start;
  logic                       cmd_abort;
  logic                       cfg_master;
  logic [ROUNDS_W-1:0]        cfg_rounds;
  // Datapath handshake
  logic                       ptp_start;
  logic                       ptp_master;
  logic                       ptp_conv_finished;
  logic [TIME_W-1:0]          ptp_travel_time;
  // Status and statistics
  logic                       busy;
  logic                       done;
  logic                       error;
  logic [ROUNDS_W-1:0]        rounds_ok;
  logic [ROUNDS_W-1:0]        rounds_fail;
  logic [TIME_W-1:0]          time_min;
  logic [TIME_W-1:0]          time_max;
  logic [TIME_W+ROUNDS_W-1:0] time_sum;

  modport master (
    output cmd_start, cmd_abort, cfg_master, cfg_rounds,
           ptp_conv_finished, ptp_travel_time,
    input  ptp_start, ptp_master, busy, done, error,
           rounds_ok, rounds_fail, time_min, time_max, time_sum
  );

  modport slave (
    input  cmd_start, cmd_abort, cfg_master, cfg_rounds,
           ptp_conv_finished, ptp_travel_time,
    output ptp_start, ptp_master, busy, done, error,
           rounds_ok, rounds_fail, time_min, time_max, time_sum
  );
endinterface

// File: rtl/ptp_session_sequencer.sv
// Multi-round PTP measurement sequencer: fires one ptp_start per round,
// waits for a fresh convergence or a timeout, leaves a guard gap for piezo
// ringing, and accumulates min/max/sum travel-time statistics.
module ptp_session_sequencer #(
  parameter int unsigned ROUNDS_W       = 4,
  parameter int unsigned TIME_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned GUARD_CYCLES   = 1000000
) (
  input  logic                   clock,
  input  logic                   reset,
  ptp_session_sequencer_if.slave bus
);

  localparam int unsigned SUM_W   = TIME_W + ROUNDS_W;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GUARD,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;          // timeout count in WAIT, gap count in GUARD
  logic                armed_q;        // a low conv flag has been seen this round
  logic [ROUNDS_W-1:0] round_idx_q;
  logic [ROUNDS_W-1:0] last_idx_q;     // index of the final round of the session

  logic                ptp_start_q, ptp_master_q, busy_q, done_q, error_q;
  logic [ROUNDS_W-1:0] rounds_ok_q, rounds_fail_q;
  logic [TIME_W-1:0]   time_min_q, time_max_q;
  logic [SUM_W-1:0]    time_sum_q;

  logic start_ok, abort, accept, timeout, sample_valid, guard_done, last_round;

  assign start_ok     = bus.cmd_start && !bus.cmd_abort;
  assign abort        = (state_q != S_IDLE) && bus.cmd_abort;
  assign accept       = armed_q && bus.ptp_conv_finished;
  assign timeout      = (cnt_q == TMO_LAST);
  assign sample_valid = (bus.ptp_travel_time > TIME_W'(1));
  assign guard_done   = (cnt_q == GRD_LAST);
  assign last_round   = (round_idx_q == last_idx_q);

  // State register
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; abort overrides every non-IDLE transition
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_ok) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (accept || timeout) state_d = S_GUARD;
      S_GUARD:  if (guard_done) state_d = last_round ? S_FINISH : S_START;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Registered outputs, counters and statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      round_idx_q   <= '0;
      last_idx_q    <= '0;
      ptp_start_q   <= 1'b0;
      ptp_master_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      rounds_ok_q   <= '0;
      rounds_fail_q <= '0;
      time_min_q    <= '1;
      time_max_q    <= '0;
      time_sum_q    <= '0;
    end else begin
      ptp_start_q <= (state_d == S_START);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FINISH);

      if (abort) begin
        // Stats freeze as they stand; role stays driven.
        error_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_ok) begin
              ptp_master_q  <= bus.cfg_master;
              last_idx_q    <= (bus.cfg_rounds == '0) ? '0 : bus.cfg_rounds - ROUNDS_W'(1);
              round_idx_q   <= '0;
              error_q       <= 1'b0;
              rounds_ok_q   <= '0;
              rounds_fail_q <= '0;
              time_min_q    <= '1;
              time_max_q    <= '0;
              time_sum_q    <= '0;
            end
          end
          S_START: begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
          end
          S_WAIT: begin
            cnt_q   <= cnt_q + CNT_W'(1);
            // A high flag is only trusted after it has been seen low, which
            // rejects the stale flag left over from the previous round.
            armed_q <= armed_q | ~bus.ptp_conv_finished;
            if (accept) begin
              cnt_q <= '0;
              if (sample_valid) begin
                rounds_ok_q <= rounds_ok_q + ROUNDS_W'(1);
                time_sum_q  <= time_sum_q + SUM_W'(bus.ptp_travel_time);
                if (bus.ptp_travel_time < time_min_q) time_min_q <= bus.ptp_travel_time;
                if (bus.ptp_travel_time > time_max_q) time_max_q <= bus.ptp_travel_time;
              end else begin
                rounds_fail_q <= rounds_fail_q + ROUNDS_W'(1);
                error_q       <= 1'b1;
              end
            end else if (timeout) begin
              cnt_q         <= '0;
              rounds_fail_q <= rounds_fail_q + ROUNDS_W'(1);
              error_q       <= 1'b1;
            end
          end
          S_GUARD: begin
            if (guard_done) begin
              if (last_round) begin
                if (rounds_ok_q == '0) time_min_q <= '0;
              end else begin
                round_idx_q <= round_idx_q + ROUNDS_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.ptp_start   = ptp_start_q;
  assign bus.ptp_master  = ptp_master_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.rounds_ok   = rounds_ok_q;
  assign bus.rounds_fail = rounds_fail_q;
  assign bus.time_min    = time_min_q;
  assign bus.time_max    = time_max_q;
  assign bus.time_sum    = time_sum_q;

endmodule

// File: tb/tb_ptp_session_sequencer.sv
// Directed bench for ptp_session_sequencer with a small ptp_sync datapath model.
`timescale 1ns/1ps
module tb_ptp_session_sequencer;
  localparam int unsigned ROUNDS_W       = 4;
  localparam int unsigned TIME_W         = 32;
  localparam int unsigned TIMEOUT_CYCLES = 100;
  localparam int unsigned GUARD_CYCLES   = 10;
  localparam int          DROP_K         = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ptp_session_sequencer_if #(.ROUNDS_W(ROUNDS_W), .TIME_W(TIME_W)) bus ();

  ptp_session_sequencer #(
    .ROUNDS_W(ROUNDS_W), .TIME_W(TIME_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GUARD_CYCLES(GUARD_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Written by the stimulus process only
  bit          hold_high = 1'b0;
  int          rise_k    = 20;
  int          times_base = 0;
  int unsigned times [8];

  // Written by the model process only
  int cyc = 0, start_cnt = 0, done_cnt = 0, done_cyc = 0;
  int start_cycs [$];
  int m_k = 0, m_idx = 0;
  bit m_active = 1'b0;

  // Datapath model and event monitor, evaluated on the falling edge
  initial begin
    bus.ptp_conv_finished = 1'b0;
    bus.ptp_travel_time   = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.ptp_start) begin
        m_idx = start_cnt - times_base;
        start_cnt++;
        start_cycs.push_back(cyc);
        m_k = 0;
        m_active = 1'b1;
      end else if (m_active) begin
        m_k++;
      end
      if (hold_high) begin
        bus.ptp_conv_finished = 1'b1;
      end else if (m_active) begin
        if (m_k == DROP_K) bus.ptp_conv_finished = 1'b0;
        if (m_k == rise_k) begin
          bus.ptp_conv_finished = 1'b1;
          bus.ptp_travel_time = (m_idx >= 0 && m_idx < 8) ? times[m_idx] : 32'd777;
          m_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic master, input logic [ROUNDS_W-1:0] rounds);
    bus.cmd_start  = 1'b1;
    bus.cfg_master = master;
    bus.cfg_rounds = rounds;
    @(negedge clock);
    bus.cmd_start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (bus.done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({bus.busy, bus.done, bus.ptp_start, bus.ptp_master, bus.error} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.busy, bus.done, bus.ptp_start, bus.ptp_master, bus.error});
    end
    tests_run++;
    if (bus.rounds_ok !== 4'd0 || bus.rounds_fail !== 4'd0) begin
      tests_failed++; $display("FAIL reset_counters: got ok=%0d fail=%0d expected 0/0", bus.rounds_ok, bus.rounds_fail);
    end
    tests_run++;
    if (bus.time_min !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL reset_min: got %h expected ffffffff", bus.time_min);
    end
    tests_run++;
    if (bus.time_max !== 32'd0 || bus.time_sum !== 36'd0) begin
      tests_failed++; $display("FAIL reset_max_sum: got max=%0d sum=%0d expected 0/0", bus.time_max, bus.time_sum);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_three_rounds();
    int sc0, n0;
    bit seen;
    sc0 = start_cnt; n0 = start_cycs.size();
    times_base = start_cnt;
    times[0] = 500; times[1] = 520; times[2] = 480;
    pulse_start(1'b1, 4'd3);
    tests_run++;
    if ({bus.busy, bus.ptp_master, bus.ptp_start} !== 3'b111) begin
      tests_failed++; $display("FAIL t1_start_cycle: got busy/master/start=%b expected 111",
                               {bus.busy, bus.ptp_master, bus.ptp_start});
    end
    wait_done(1000, seen);
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL t1_done: got no done expected done pulse"); end
    tests_run++;
    if (bus.rounds_ok !== 4'd3 || bus.rounds_fail !== 4'd0) begin
      tests_failed++; $display("FAIL t1_counters: got ok=%0d fail=%0d expected 3/0", bus.rounds_ok, bus.rounds_fail);
    end
    tests_run++;
    if (bus.time_min !== 32'd480 || bus.time_max !== 32'd520) begin
      tests_failed++; $display("FAIL t1_min_max: got %0d/%0d expected 480/520", bus.time_min, bus.time_max);
    end
    tests_run++;
    if (bus.time_sum !== 36'd1500 || bus.error !== 1'b0) begin
      tests_failed++; $display("FAIL t1_sum_err: got sum=%0d err=%b expected 1500/0", bus.time_sum, bus.error);
    end
    @(negedge clock);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL t1_end_idle: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    tests_run++;
    if (start_cnt - sc0 !== 3) begin
      tests_failed++; $display("FAIL t1_start_pulses: got %0d expected 3", start_cnt - sc0);
    end
    tests_run++;
    if (start_cycs.size() < n0 + 3 || start_cycs[n0+1] - start_cycs[n0] !== 32) begin
      tests_failed++; $display("FAIL t1_round_spacing: got %0d expected 32",
                               (start_cycs.size() > n0 + 1) ? start_cycs[n0+1] - start_cycs[n0] : -1);
    end
    tests_run++;
    if (start_cycs.size() < n0 + 3 || done_cyc - start_cycs[n0+2] !== 32) begin
      tests_failed++; $display("FAIL t1_done_timing: got %0d expected 32",
                               (start_cycs.size() > n0 + 2) ? done_cyc - start_cycs[n0+2] : -1);
    end
  endtask

  task automatic test_stale_high();
    int n0;
    bit seen;
    hold_high = 1'b1;
    @(negedge clock);
    n0 = start_cycs.size();
    pulse_start(1'b0, 4'd1);
    wait_done(400, seen);
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL t2_done: got no done expected done pulse"); end
    tests_run++;
    if (bus.rounds_fail !== 4'd1 || bus.rounds_ok !== 4'd0 || bus.error !== 1'b1) begin
      tests_failed++; $display("FAIL t2_timeout: got fail=%0d ok=%0d err=%b expected 1/0/1",
                               bus.rounds_fail, bus.rounds_ok, bus.error);
    end
    tests_run++;
    if (bus.time_min !== 32'd0 || bus.time_max !== 32'd0 || bus.time_sum !== 36'd0) begin
      tests_failed++; $display("FAIL t2_stats: got min=%0d max=%0d sum=%0d expected 0/0/0",
                               bus.time_min, bus.time_max, bus.time_sum);
    end
    @(negedge clock);
    tests_run++;
    if (start_cycs.size() < n0 + 1 || done_cyc - start_cycs[n0] !== 112) begin
      tests_failed++; $display("FAIL t2_timeout_timing: got %0d expected 112",
                               (start_cycs.size() > n0) ? done_cyc - start_cycs[n0] : -1);
    end
    hold_high = 1'b0;
  endtask

  task automatic test_invalid_sample();
    bit seen;
    times_base = start_cnt;
    times[0] = 1; times[1] = 300;
    pulse_start(1'b1, 4'd2);
    tests_run++;
    if (bus.error !== 1'b0) begin
      tests_failed++; $display("FAIL t3_error_cleared: got %b expected 0", bus.error);
    end
    wait_done(400, seen);
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL t3_done: got no done expected done pulse"); end
    tests_run++;
    if (bus.rounds_ok !== 4'd1 || bus.rounds_fail !== 4'd1 || bus.error !== 1'b1) begin
      tests_failed++; $display("FAIL t3_counters: got ok=%0d fail=%0d err=%b expected 1/1/1",
                               bus.rounds_ok, bus.rounds_fail, bus.error);
    end
    tests_run++;
    if (bus.time_min !== 32'd300 || bus.time_max !== 32'd300 || bus.time_sum !== 36'd300) begin
      tests_failed++; $display("FAIL t3_stats: got min=%0d max=%0d sum=%0d expected 300/300/300",
                               bus.time_min, bus.time_max, bus.time_sum);
    end
    @(negedge clock);
  endtask

  task automatic test_abort();
    int sc, dn, seen_starts;
    bit seen;
    times_base = start_cnt;
    times[0] = 400; times[1] = 410; times[2] = 420; times[3] = 430;
    pulse_start(1'b1, 4'd4);
    seen_starts = 0;
    for (int i = 0; i < 200 && seen_starts == 0; i++) begin
      @(negedge clock);
      if (bus.ptp_start) seen_starts++;
    end
    tests_run++;
    if (seen_starts != 1) begin tests_failed++; $display("FAIL t4_round2_start: got none expected start pulse"); end
    repeat (5) @(negedge clock);
    bus.cmd_abort = 1'b1;
    @(negedge clock);
    bus.cmd_abort = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b1) begin
      tests_failed++; $display("FAIL t4_abort_state: got busy=%b done=%b err=%b expected 0/0/1",
                               bus.busy, bus.done, bus.error);
    end
    tests_run++;
    if (bus.rounds_ok !== 4'd1 || bus.time_sum !== 36'd400 || bus.ptp_master !== 1'b1) begin
      tests_failed++; $display("FAIL t4_frozen: got ok=%0d sum=%0d master=%b expected 1/400/1",
                               bus.rounds_ok, bus.time_sum, bus.ptp_master);
    end
    sc = start_cnt; dn = done_cnt;
    repeat (40) @(negedge clock);
    tests_run++;
    if (start_cnt !== sc || done_cnt !== dn) begin
      tests_failed++; $display("FAIL t4_quiet: got starts+%0d dones+%0d expected 0/0", start_cnt - sc, done_cnt - dn);
    end
    times_base = start_cnt;
    times[0] = 250;
    pulse_start(1'b0, 4'd0);
    tests_run++;
    if (bus.error !== 1'b0 || bus.rounds_ok !== 4'd0 || bus.rounds_fail !== 4'd0 || bus.ptp_master !== 1'b0) begin
      tests_failed++; $display("FAIL t4_restart_clear: got err=%b ok=%0d fail=%0d master=%b expected 0/0/0/0",
                               bus.error, bus.rounds_ok, bus.rounds_fail, bus.ptp_master);
    end
    tests_run++;
    if (bus.time_min !== 32'hFFFF_FFFF || bus.time_max !== 32'd0 || bus.time_sum !== 36'd0) begin
      tests_failed++; $display("FAIL t4_restart_stats: got min=%h max=%0d sum=%0d expected ffffffff/0/0",
                               bus.time_min, bus.time_max, bus.time_sum);
    end
    wait_done(200, seen);
    tests_run++;
    if (!seen || bus.rounds_ok !== 4'd1 || bus.time_min !== 32'd250) begin
      tests_failed++; $display("FAIL t4_zero_rounds: got done=%b ok=%0d min=%0d expected 1/1/250",
                               seen, bus.rounds_ok, bus.time_min);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int sc;
    bit seen;
    sc = start_cnt;
    bus.cmd_start = 1'b1; bus.cmd_abort = 1'b1; bus.cfg_rounds = 4'd2; bus.cfg_master = 1'b1;
    @(negedge clock);
    bus.cmd_start = 1'b0; bus.cmd_abort = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.ptp_start !== 1'b0) begin
      tests_failed++; $display("FAIL t5_start_abort: got busy=%b start=%b expected 0/0", bus.busy, bus.ptp_start);
    end
    repeat (5) @(negedge clock);
    tests_run++;
    if (start_cnt !== sc) begin
      tests_failed++; $display("FAIL t5_no_session: got %0d starts expected 0", start_cnt - sc);
    end
    times_base = start_cnt;
    times[0] = 350;
    pulse_start(1'b1, 4'd1);
    repeat (3) @(negedge clock);
    pulse_start(1'b0, 4'd5);
    tests_run++;
    if (bus.ptp_master !== 1'b1 || bus.busy !== 1'b1) begin
      tests_failed++; $display("FAIL t5_busy_start: got master=%b busy=%b expected 1/1", bus.ptp_master, bus.busy);
    end
    wait_done(200, seen);
    tests_run++;
    if (!seen || bus.rounds_ok !== 4'd1 || bus.rounds_fail !== 4'd0) begin
      tests_failed++; $display("FAIL t5_session: got done=%b ok=%0d fail=%0d expected 1/1/0",
                               seen, bus.rounds_ok, bus.rounds_fail);
    end
    @(negedge clock);
    tests_run++;
    if (start_cnt - sc !== 1) begin
      tests_failed++; $display("FAIL t5_pulse_count: got %0d expected 1", start_cnt - sc);
    end
  endtask

  task automatic test_accept_timeout();
    int sc;
    bit seen;
    times_base = start_cnt;
    times[0] = 600;
    rise_k = 100;
    pulse_start(1'b1, 4'd1);
    wait_done(400, seen);
    rise_k = 20;
    tests_run++;
    if (!seen || bus.rounds_ok !== 4'd1 || bus.rounds_fail !== 4'd0 || bus.error !== 1'b0) begin
      tests_failed++; $display("FAIL t6_accept_wins: got done=%b ok=%0d fail=%0d err=%b expected 1/1/0/0",
                               seen, bus.rounds_ok, bus.rounds_fail, bus.error);
    end
    tests_run++;
    if (bus.time_min !== 32'd600 || bus.time_max !== 32'd600 || bus.time_sum !== 36'd600) begin
      tests_failed++; $display("FAIL t6_stats: got min=%0d max=%0d sum=%0d expected 600/600/600",
                               bus.time_min, bus.time_max, bus.time_sum);
    end
    @(negedge clock);
    times_base = start_cnt;
    times[0] = 610; times[1] = 620;
    pulse_start(1'b1, 4'd2);
    repeat (25) @(negedge clock);
    tests_run++;
    if (bus.busy !== 1'b1 || bus.rounds_ok !== 4'd1) begin
      tests_failed++; $display("FAIL t6_in_guard: got busy=%b ok=%0d expected 1/1", bus.busy, bus.rounds_ok);
    end
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({bus.busy, bus.done, bus.ptp_start, bus.ptp_master, bus.error} !== 5'b0 ||
        bus.rounds_ok !== 4'd0 || bus.rounds_fail !== 4'd0) begin
      tests_failed++; $display("FAIL t6_reset_flags: got flags=%b ok=%0d fail=%0d expected 00000/0/0",
                               {bus.busy, bus.done, bus.ptp_start, bus.ptp_master, bus.error},
                               bus.rounds_ok, bus.rounds_fail);
    end
    tests_run++;
    if (bus.time_min !== 32'hFFFF_FFFF || bus.time_max !== 32'd0 || bus.time_sum !== 36'd0) begin
      tests_failed++; $display("FAIL t6_reset_stats: got min=%h max=%0d sum=%0d expected ffffffff/0/0",
                               bus.time_min, bus.time_max, bus.time_sum);
    end
    reset = 1'b0;
    sc = start_cnt;
    repeat (40) @(negedge clock);
    tests_run++;
    if (start_cnt !== sc || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL t6_post_reset: got starts+%0d busy=%b expected 0/0", start_cnt - sc, bus.busy);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.cmd_start  = 1'b0;
    bus.cmd_abort  = 1'b0;
    bus.cfg_master = 1'b0;
    bus.cfg_rounds = '0;
    test_reset();
    test_three_rounds();
    test_stale_high();
    test_invalid_sample();
    test_abort();
    test_back_to_back();
    test_accept_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
